// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the sequence detectors.
package seq_pkg;

  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned REP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_A = 2'd1,
    ST_RUN_B = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/run_len_counter.sv
// Loadable down-counter; tc_c flags the last cycle of the current run.
module run_len_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Emits len_a cycles of first_bit then len_b cycles of its complement, rep times (0 = endless).
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             first_bit,
  input  logic [LEN_W-1:0] len_a,
  input  logic [LEN_W-1:0] len_b,
  input  logic [REP_W-1:0] rep,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] pair_cnt
);

  state_t             state, state_d;
  logic               fb_q, fb_d;
  logic [LEN_W-1:0]   len_a_q, len_a_d, len_b_q, len_b_d;
  logic [REP_W-1:0]   rep_q, rep_d, pair_cnt_d;
  logic               bit_out_d, bit_valid_d, busy_d, done_d;
  logic               cnt_load_c, cnt_en_c, cnt_tc_c;
  logic [LEN_W-1:0]   cnt_val_c;

  // A zero length behaves as one cycle, so the reload value is max(len,1)-1.
  function automatic logic [LEN_W-1:0] reload_of(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - LEN_W'(1);
  endfunction

  run_len_counter #(.W(LEN_W)) u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .en       (cnt_en_c),
    .load_val (cnt_val_c),
    .tc_c     (cnt_tc_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      fb_q      <= 1'b0;
      len_a_q   <= '0;
      len_b_q   <= '0;
      rep_q     <= '0;
      pair_cnt  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      fb_q      <= fb_d;
      len_a_q   <= len_a_d;
      len_b_q   <= len_b_d;
      rep_q     <= rep_d;
      pair_cnt  <= pair_cnt_d;
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next state, config latch and run-counter control; outputs follow the next state.
  always_comb begin
    state_d     = state;
    fb_d        = fb_q;
    len_a_d     = len_a_q;
    len_b_d     = len_b_q;
    rep_d       = rep_q;
    pair_cnt_d  = pair_cnt;
    cnt_load_c  = 1'b0;
    cnt_en_c    = 1'b0;
    cnt_val_c   = '0;

    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          fb_d       = first_bit;
          len_a_d    = len_a;
          len_b_d    = len_b;
          rep_d      = rep;
          pair_cnt_d = '0;
          cnt_load_c = 1'b1;
          cnt_val_c  = reload_of(len_a);
          state_d    = ST_RUN_A;
        end
      end
      ST_RUN_A: begin
        if (cnt_tc_c) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = reload_of(len_b_q);
          state_d    = ST_RUN_B;
        end else begin
          cnt_en_c = 1'b1;
        end
      end
      ST_RUN_B: begin
        if (cnt_tc_c) begin
          pair_cnt_d = pair_cnt + REP_W'(1);
          if ((rep_q != '0) && (pair_cnt_d == rep_q)) begin
            state_d = ST_DONE;
          end else begin
            cnt_load_c = 1'b1;
            cnt_val_c  = reload_of(len_a_q);
            state_d    = ST_RUN_A;
          end
        end else begin
          cnt_en_c = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including the final pair increment.
    if (stop) begin
      state_d    = ST_IDLE;
      pair_cnt_d = pair_cnt;
      cnt_load_c = 1'b0;
      cnt_en_c   = 1'b0;
    end

    busy_d      = (state_d == ST_RUN_A) || (state_d == ST_RUN_B);
    bit_valid_d = busy_d;
    done_d      = (state_d == ST_DONE);
    bit_out_d   = (state_d == ST_RUN_A) ? fb_d :
                  (state_d == ST_RUN_B) ? ~fb_d : 1'b0;
  end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter LEN_W, default 4: width of each run-length field.
REQ-002 SHALL have parameter REP_W, default 8: width of the pair-repeat count.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: begin a pattern; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1: abort the pattern; sampled in any state.
REQ-007 SHALL have port first_bit, input, 1: level of run A; run B is its complement.
REQ-008 SHALL have port len_a, input, LEN_W: run A length in clk cycles.
REQ-009 SHALL have port len_b, input, LEN_W: run B length in clk cycles.
REQ-010 SHALL have port rep, input, REP_W: number of A+B pairs; 0 means endless.
REQ-011 SHALL have port bit_out, output, 1: serial pattern bit, the stream consumed by the team's serial sequence detectors.
REQ-012 SHALL have port bit_valid, output, 1: high while bit_out carries pattern data.
REQ-013 SHALL have port busy, output, 1: high in RUN_A or RUN_B.
REQ-014 SHALL have port done, output, 1: single-cycle pulse on normal completion.
REQ-015 SHALL have port pair_cnt, output, REP_W: completed pairs so far.

Function
REQ-016 SHALL implement states IDLE, RUN_A, RUN_B, DONE.
REQ-017 SHALL, in IDLE with start=1, latch first_bit, len_a, len_b and rep, clear pair_cnt, and enter RUN_A; bit_valid rises on the next cycle (latency 1).
REQ-018 SHALL ignore config input changes after the latch until the next start.
REQ-019 SHALL clamp a latched length of 0 to 1.
REQ-020 SHALL drive bit_out=first_bit for exactly len_a cycles in RUN_A, then bit_out=~first_bit for exactly len_b cycles in RUN_B.
REQ-021 SHALL, at the end of RUN_B, increment pair_cnt, then enter DONE if pair_cnt+1 equals a non-zero rep, else re-enter RUN_A with no gap cycle.
REQ-022 SHALL assert done for one cycle in DONE, then return to IDLE.
REQ-023 SHALL wrap pair_cnt modulo 2^REP_W when rep=0.
REQ-024 SHALL give stop priority over every other event: go to IDLE on the next edge with no done pulse; pair_cnt holds its value.
REQ-025 SHALL treat start and stop asserted together in IDLE as stop, and stay in IDLE.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL drive bit_out=0 and bit_valid=0 in IDLE and DONE.

Reset
REQ-028 SHALL, while rst=0, immediately force IDLE, with bit_out=0, bit_valid=0, busy=0, done=0, pair_cnt=0, run counter 0, and latched config 0.
REQ-029 SHALL, on reset mid-pattern, discard the pattern and require a new start after rst returns high.

Structure
REQ-030 SHALL place the state encoding constants and the default LEN_W/REP_W values in the shared package seq_pkg, which the detector FSMs also use.
REQ-031 SHALL use one sub-module, run_len_counter: loadable down-counter with a terminal-count flag, instantiated once and reloaded at each run boundary.

Verification
REQ-032 Bench SHALL cover: first_bit=0, len_a=5, len_b=5, rep=3 -> 00000111110000011111 0000011111, done at cycle 31 after start, pair_cnt=3.
REQ-033 Bench SHALL cover: len_a=0, len_b=2, first_bit=1, rep=2 -> 100100, then done.
REQ-034 Bench SHALL cover: stop asserted in the 3rd cycle of RUN_B with pair_cnt=1 -> IDLE next edge, bit_valid=0, no done, pair_cnt stays 1.
REQ-035 Bench SHALL cover: rst low mid-RUN_A -> all outputs 0 asynchronously; start after release -> a fresh pattern.
REQ-036 Bench SHALL cover: rep=0, len_a=1, len_b=1 for 600 cycles -> alternating 1010..., pair_cnt wraps 255->0, done never asserted.
REQ-037 Bench SHALL cover: bit_out looped into the team's 4-in-a-row sequence detector with len_a=5, len_b=5 -> detector output high on the 4th and 5th bit of every run.
